// File: rtl/pwm_axil_pkg.sv
// rtl/pwm_axil_pkg.sv - shared response codes and FSM state types for the PWM AXI4-Lite front end
package pwm_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/pwm_axil_slave.sv
// rtl/pwm_axil_slave.sv - AXI4-Lite slave converting bus transactions into single-cycle register ports
module pwm_axil_slave
    import pwm_axil_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_WIDTH      = 16,
    parameter int NUM_CHANNELS   = 4,
    parameter int NUM_REGS       = 2 + 2 * NUM_CHANNELS,
    parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int AXI_ADDR_WIDTH = REG_ADDR_WIDTH + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,

    output logic                      write_en,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [REG_WIDTH-1:0]      write_data,

    output logic                      read_en,
    output logic [REG_ADDR_WIDTH-1:0] read_addr,
    input  logic [REG_WIDTH-1:0]      read_data,
    input  logic                      read_valid
);

    localparam int STRB_BITS = REG_WIDTH / 8;

    function automatic logic idx_legal(input logic [REG_ADDR_WIDTH-1:0] idx);
        return 32'(idx) < $unsigned(NUM_REGS);
    endfunction

    // Byte-offset bits and the upper data/strobe lanes never reach a register.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, s_axi_wstrb};

    // Held low through reset so the readies only rise one clock after release.
    logic live;

    wr_state_e                 wr_state, wr_state_nxt;
    logic                      aw_held, w_held;
    logic [REG_ADDR_WIDTH-1:0] wr_idx;
    logic [REG_WIDTH-1:0]      wr_data_q;
    logic [STRB_BITS-1:0]      wr_strb_q;
    logic                      aw_hs, w_hs, wr_legal;

    rd_state_e                 rd_state, rd_state_nxt;
    logic [REG_ADDR_WIDTH-1:0] rd_idx;
    logic                      rd_err;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      ar_hs, ar_legal;

    assign aw_hs    = s_axi_awvalid && s_axi_awready;
    assign w_hs     = s_axi_wvalid && s_axi_wready;
    assign ar_hs    = s_axi_arvalid && s_axi_arready;
    assign wr_legal = idx_legal(wr_idx) && (&wr_strb_q);
    assign ar_legal = idx_legal(s_axi_araddr[REG_ADDR_WIDTH+1:2]);

    // Liveness flag: becomes 1 on the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    // Write FSM next state: execute once both address and data are in hand.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) wr_state_nxt = W_EXEC;
            W_EXEC: wr_state_nxt = W_RESP;
            W_RESP: if (s_axi_bready) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Write payload capture; AW and W are latched independently and released after the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            wr_idx    <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                wr_idx  <= s_axi_awaddr[REG_ADDR_WIDTH+1:2];
            end
            if (w_hs) begin
                w_held    <= 1'b1;
                wr_data_q <= s_axi_wdata[REG_WIDTH-1:0];
                wr_strb_q <= s_axi_wstrb[STRB_BITS-1:0];
            end
            if (wr_state == W_RESP && s_axi_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Write-side outputs decoded from state and latched payload only.
    always_comb begin
        s_axi_awready = live && (wr_state == W_IDLE) && !aw_held;
        s_axi_wready  = live && (wr_state == W_IDLE) && !w_held;
        write_en      = (wr_state == W_EXEC) && wr_legal;
        write_addr    = wr_idx;
        write_data    = wr_data_q;
        s_axi_bvalid  = (wr_state == W_RESP);
        s_axi_bresp   = RESP_OKAY;
        if (wr_state == W_RESP && !wr_legal) s_axi_bresp = RESP_SLVERR;
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Read FSM next state: illegal addresses skip the register access entirely.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = ar_legal ? R_ISSUE : R_RESP;
            R_ISSUE: rd_state_nxt = R_WAIT;
            R_WAIT:  if (read_valid) rd_state_nxt = R_RESP;
            R_RESP:  if (s_axi_rready) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read address/error capture and read-data holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx  <= '0;
            rd_err  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (ar_hs) begin
                rd_idx <= s_axi_araddr[REG_ADDR_WIDTH+1:2];
                rd_err <= !ar_legal;
                if (!ar_legal) rdata_q <= '0;
            end
            if (rd_state == R_WAIT && read_valid) begin
                rdata_q <= DATA_WIDTH'(read_data);
            end
        end
    end

    // Read-side outputs decoded from state and held registers only.
    always_comb begin
        s_axi_arready = live && (rd_state == R_IDLE);
        read_en       = (rd_state == R_ISSUE);
        read_addr     = rd_idx;
        s_axi_rvalid  = (rd_state == R_RESP);
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = RESP_OKAY;
        if (rd_state == R_RESP && rd_err) s_axi_rresp = RESP_SLVERR;
    end

endmodule

// File: tb/tb_pwm_axil_slave.sv
// tb/tb_pwm_axil_slave.sv - directed self-checking bench for pwm_axil_slave
module tb_pwm_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [5:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        read_en;
    logic [3:0]  read_addr;
    logic [15:0] read_data;
    logic        read_valid;

    pwm_axil_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file stand-in: reads see the value before a same-cycle write.
    logic [15:0] mem [16];
    logic        stall = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_valid <= 1'b0;
            read_data  <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            read_valid <= 1'b0;
            if (write_en) mem[write_addr] <= write_data;
            if (read_en && !stall) begin
                read_valid <= 1'b1;
                read_data  <= mem[read_addr];
            end
        end
    end

    int          wen_count = 0, ren_count = 0, bv_rise = 0, rv_rise = 0;
    int          wen_cyc = 0, ren_cyc = 0;
    logic [3:0]  wen_addr = '0, ren_addr = '0;
    logic [15:0] wen_data = '0;
    logic        bv_prev = 1'b0, rv_prev = 1'b0;

    // Mid-cycle monitor of register-side pulses and response rises.
    always @(negedge clk) begin
        if (write_en) begin
            wen_count++;
            wen_cyc  = cyc;
            wen_addr = write_addr;
            wen_data = write_data;
        end
        if (read_en) begin
            ren_count++;
            ren_cyc  = cyc;
            ren_addr = read_addr;
        end
        if (s_axi_bvalid && !bv_prev) bv_rise++;
        if (s_axi_rvalid && !rv_prev) rv_rise++;
        bv_prev = s_axi_bvalid;
        rv_prev = s_axi_rvalid;
    end

    int   aw_hs = 0, w_hs = 0, ar_hs = 0, bv_cyc = 0;
    logic b_stable = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_aw(input logic [5:0] a);
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_axi_awready) break;
        end
        check_eq("aw_ready", 32'(s_axi_awready), 32'd1);
        aw_hs = cyc;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_axi_wready) break;
        end
        check_eq("w_ready", 32'(s_axi_wready), 32'd1);
        w_hs = cyc;
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] a);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_axi_arready) break;
        end
        check_eq("ar_ready", 32'(s_axi_arready), 32'd1);
        ar_hs = cyc;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_b(input int hold, output logic [1:0] resp);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) break;
        end
        check_eq("b_valid", 32'(s_axi_bvalid), 32'd1);
        bv_cyc   = cyc;
        resp     = s_axi_bresp;
        b_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!s_axi_bvalid || s_axi_bresp !== resp) b_stable = 1'b0;
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        @(negedge clk);
        check_eq("b_readies_back", 32'({s_axi_awready, s_axi_wready}), 32'h3);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int hold, output logic [1:0] resp);
        @(posedge clk); #1;
        fork
            send_w(d, s);
            begin
                repeat (lead) @(posedge clk);
                if (lead > 0) #1;
                send_aw(a);
            end
        join
        wait_b(hold, resp);
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat);
        @(posedge clk); #1;
        send_ar(a);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_axi_rvalid) break;
        end
        check_eq("r_valid", 32'(s_axi_rvalid), 32'd1);
        lat  = cyc - ar_hs;
        d    = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp, rresp;
        logic [31:0] rdata;
        int          lat, w0, r0, bv0, rv0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
        check_eq("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid, write_en, read_en}), 32'h0);
        check_eq("rst_rdata", s_axi_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("release_cycle_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
        @(negedge clk);
        check_eq("after_release_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

        // Same-cycle AW/W write to index 1
        w0 = wen_count;
        do_write(6'h04, 32'h0000_1234, 4'hF, 0, 0, resp);
        check_eq("t1_wen_count", 32'(wen_count - w0), 32'd1);
        check_eq("t1_wen_addr", 32'(wen_addr), 32'd1);
        check_eq("t1_wen_data", 32'(wen_data), 32'h1234);
        check_eq("t1_wen_lat", 32'(wen_cyc - aw_hs), 32'd1);
        check_eq("t1_bvalid_lat", 32'(bv_cyc - aw_hs), 32'd2);
        check_eq("t1_bresp", 32'(resp), 32'h0);

        // W three cycles ahead of AW, then 5 cycles of B backpressure
        w0 = wen_count;
        do_write(6'h08, 32'h0000_BEEF, 4'hF, 3, 5, resp);
        check_eq("t2_w_lead", 32'(aw_hs - w_hs), 32'd3);
        check_eq("t2_wen_lat", 32'(wen_cyc - aw_hs), 32'd1);
        check_eq("t2_wen_count", 32'(wen_count - w0), 32'd1);
        check_eq("t2_wen_addr", 32'(wen_addr), 32'd2);
        check_eq("t2_wen_data", 32'(wen_data), 32'hBEEF);
        check_eq("t2_b_stable", 32'(b_stable), 32'd1);
        check_eq("t2_bresp", 32'(resp), 32'h0);

        // Illegal writes: out-of-range index and partial strobe
        w0 = wen_count;
        do_write(6'h28, 32'h0000_1111, 4'hF, 0, 0, resp);
        check_eq("t3_range_bresp", 32'(resp), 32'h2);
        do_write(6'h00, 32'h0000_2222, 4'h1, 0, 0, resp);
        check_eq("t3_strb_bresp", 32'(resp), 32'h2);
        check_eq("t3_no_wen", 32'(wen_count - w0), 32'd0);

        // Last legal index, byte offset ignored, upper data and strobe lanes dropped
        w0 = wen_count;
        do_write(6'h26, 32'hFFFF_A5A5, 4'h3, 0, 0, resp);
        check_eq("t3b_wen_count", 32'(wen_count - w0), 32'd1);
        check_eq("t3b_wen_addr", 32'(wen_addr), 32'd9);
        check_eq("t3b_wen_data", 32'(wen_data), 32'hA5A5);
        check_eq("t3b_bresp", 32'(resp), 32'h0);

        // Legal read of the first write
        r0 = ren_count;
        do_read(6'h04, rdata, rresp, lat);
        check_eq("t4_rdata", rdata, 32'h0000_1234);
        check_eq("t4_rresp", 32'(rresp), 32'h0);
        check_eq("t4_rvalid_lat", 32'(lat), 32'd3);
        check_eq("t4_ren_lat", 32'(ren_cyc - ar_hs), 32'd1);
        check_eq("t4_ren_addr", 32'(ren_addr), 32'd1);
        check_eq("t4_ren_count", 32'(ren_count - r0), 32'd1);
        do_read(6'h24, rdata, rresp, lat);
        check_eq("t4_idx9_rdata", rdata, 32'h0000_A5A5);

        // Illegal read
        r0 = ren_count;
        do_read(6'h3C, rdata, rresp, lat);
        check_eq("t4_bad_rdata", rdata, 32'h0);
        check_eq("t4_bad_rresp", 32'(rresp), 32'h2);
        check_eq("t4_bad_lat", 32'(lat), 32'd1);
        check_eq("t4_bad_no_ren", 32'(ren_count - r0), 32'd0);

        // Concurrent read and write of index 3
        fork
            do_write(6'h0C, 32'h0000_00FF, 4'hF, 0, 0, resp);
            do_read(6'h0C, rdata, rresp, lat);
        join
        check_eq("t5_same_cycle", 32'(wen_cyc - ren_cyc), 32'd0);
        check_eq("t5_old_value", rdata, 32'h0);
        do_read(6'h0C, rdata, rresp, lat);
        check_eq("t5_new_value", rdata, 32'h0000_00FF);

        // Reset while write sits in W_RESP and read sits in R_WAIT
        stall = 1'b1;
        @(posedge clk); #1;
        fork
            send_w(32'h0000_3333, 4'hF);
            send_aw(6'h10);
        join
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) break;
        end
        check_eq("t6_bvalid_before_rst", 32'(s_axi_bvalid), 32'd1);
        @(posedge clk); #1;
        send_ar(6'h04);
        repeat (3) @(negedge clk);
        check_eq("t6_waiting_read", 32'({s_axi_rvalid, s_axi_arready}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        w0  = wen_count;
        r0  = ren_count;
        bv0 = bv_rise;
        rv0 = rv_rise;
        @(negedge clk);
        check_eq("t6_rst_outputs", 32'({s_axi_bvalid, s_axi_rvalid, write_en, read_en}), 32'h0);
        check_eq("t6_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_readies_back", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
        repeat (5) @(negedge clk);
        check_eq("t6_no_events", 32'({8'(wen_count - w0), 8'(ren_count - r0), 8'(bv_rise - bv0), 8'(rv_rise - rv0)}), 32'h0);

        w0 = wen_count;
        do_write(6'h14, 32'h0000_5A5A, 4'hF, 0, 0, resp);
        check_eq("t6_post_bresp", 32'(resp), 32'h0);
        check_eq("t6_post_wen", 32'(wen_count - w0), 32'd1);
        do_read(6'h14, rdata, rresp, lat);
        check_eq("t6_post_rdata", rdata, 32'h0000_5A5A);
        check_eq("t6_post_rresp", 32'(rresp), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
